// File: rtl/apb_slv_pkg.sv
// Shared types and helpers for the APB4 memory slave.
package apb_slv_pkg;

  // Slave FSM. SETUP is entered right after a completed transfer.
  // There the bus may present a back-to-back setup phase, or return to idle.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_slv_state_e;

  localparam int APB_ADDR_W_DEF    = 32;
  localparam int APB_DATA_W_DEF    = 32;
  localparam int APB_MEM_DEPTH_DEF = 256;
  localparam int APB_MAX_WAIT_DEF  = 7;

  // Number of byte lanes in a data word.
  function automatic int num_lanes(input int dw);
    return dw / 8;
  endfunction

  // Byte-offset bits inside a word (0 for 8-bit data).
  function automatic int lane_off_w(input int dw);
    return (dw / 8 > 1) ? $clog2(dw / 8) : 0;
  endfunction

  // Word index width for a memory of the given depth.
  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/apb_slv_mem.sv
// Byte-lane RAM: DATA_WIDTH x MEM_DEPTH, per-lane write enable,
// asynchronous clear to zero and combinational read.
module apb_slv_mem
  import apb_slv_pkg::*;
#(
  parameter int DATA_WIDTH = APB_DATA_W_DEF,
  parameter int MEM_DEPTH  = APB_MEM_DEPTH_DEF,
  parameter int NUM_LANES  = num_lanes(DATA_WIDTH),
  parameter int IDX_W      = idx_w(MEM_DEPTH)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [IDX_W-1:0]          addr_i,
  input  logic [NUM_LANES-1:0]      we_i,
  input  logic [NUM_LANES-1:0][7:0] wdata_i,
  output logic [NUM_LANES-1:0][7:0] rdata_o
);

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [7:0] lane_q [MEM_DEPTH];

    // One byte column: cleared on reset, written when its lane enable is set.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < MEM_DEPTH; i++) lane_q[i] <= '0;
      end else if (we_i[l]) begin
        lane_q[addr_i] <= wdata_i[l];
      end
    end

    assign rdata_o[l] = lane_q[addr_i];
  end

endmodule

// File: rtl/apb4_mem_slave.sv
// APB4 memory slave with programmable wait states, range/alignment
// checking and a sticky protocol-violation flag.
// Optional feature: define APB_SLV_STRB_EN to honour PSTRB per byte lane.
// When it is undefined, every write updates the full word.
module apb4_mem_slave
  import apb_slv_pkg::*;
#(
  parameter int ADDR_WIDTH = APB_ADDR_W_DEF,
  parameter int DATA_WIDTH = APB_DATA_W_DEF,
  parameter int MEM_DEPTH  = APB_MEM_DEPTH_DEF,
  parameter int MAX_WAIT   = APB_MAX_WAIT_DEF
) (
  input  logic                          PCLK,
  input  logic                          PRESETn,
  input  logic                          PSELx,
  input  logic                          PENABLE,
  input  logic                          PWRITE,
  input  logic [ADDR_WIDTH-1:0]         PADDR,
  input  logic [DATA_WIDTH-1:0]         PWDATA,
  input  logic [DATA_WIDTH/8-1:0]       PSTRB,
  input  logic [$clog2(MAX_WAIT+1)-1:0] wait_cycles,
  input  logic                          err_clr,
  output logic                          PREADY,
  output logic                          PSLVERR,
  output logic [DATA_WIDTH-1:0]         PRDATA,
  output logic                          err_sticky
);

  localparam int NUM_LANES = num_lanes(DATA_WIDTH);
  localparam int OFF_W     = lane_off_w(DATA_WIDTH);
  localparam int IDX_W     = idx_w(MEM_DEPTH);
  localparam int WC_W      = $clog2(MAX_WAIT + 1);

  apb_slv_state_e          state_q, state_d;
  logic [WC_W-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    write_q, write_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [NUM_LANES-1:0]    strb_q, strb_d;
  logic                    pready_q, pready_d;
  logic                    pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
  logic                    err_q, err_d;

  logic                    viol, raise, complete;
  logic [WC_W-1:0]         wc_sat;
  logic [ADDR_WIDTH-1:0]   cur_addr, cur_idx;
  logic                    cur_write, cur_err;
  logic [NUM_LANES-1:0]    lane_en, mem_we;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  // Requested wait count, clipped to the largest supported value.
  always_comb begin
    wc_sat = (wait_cycles > WC_W'(MAX_WAIT)) ? WC_W'(MAX_WAIT) : wait_cycles;
  end

  // Decode the transfer being answered. Use the bus directly on the setup edge
  // (zero-wait reads need data there); otherwise use the latched request.
  always_comb begin
    cur_addr  = (state_q == ACCESS) ? addr_q  : PADDR;
    cur_write = (state_q == ACCESS) ? write_q : PWRITE;
    cur_idx   = cur_addr >> OFF_W;
    cur_err   = (cur_idx >= ADDR_WIDTH'(MEM_DEPTH)) ||
                ((cur_addr & ADDR_WIDTH'(NUM_LANES - 1)) != '0);
  end

`ifdef APB_SLV_STRB_EN
  // Byte lanes follow the latched strobes.
  always_comb lane_en = strb_q;
`else
  // Strobes are latched but overridden; every write covers the full word.
  always_comb lane_en = strb_q | {NUM_LANES{1'b1}};
`endif

  // Commit only on the completing edge of an error-free write.
  always_comb begin
    mem_we = (complete && write_q && !cur_err) ? lane_en : '0;
  end

  apb_slv_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_mem (
    .clk_i   (PCLK),
    .rst_ni  (PRESETn),
    .addr_i  (cur_idx[IDX_W-1:0]),
    .we_i    (mem_we),
    .wdata_i (wdata_q),
    .rdata_o (mem_rdata)
  );

  // Next-state, wait countdown, request latch and registered responses.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    prdata_d  = prdata_q;
    viol      = 1'b0;
    raise     = 1'b0;
    complete  = 1'b0;

    unique case (state_q)
      IDLE, SETUP: begin
        if (PENABLE) begin
          viol = 1'b1;
        end else if (PSELx) begin
          addr_d  = PADDR;
          write_d = PWRITE;
          wdata_d = PWDATA;
          strb_d  = PSTRB;
          cnt_d   = wc_sat;
          state_d = ACCESS;
          raise   = (wc_sat == '0);
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (!PSELx) begin
          viol = 1'b1;
        end else if (pready_q) begin
          // PREADY lasts one cycle whether or not the master completed.
          // An access phase without PENABLE is abandoned quietly.
          complete  = PENABLE;
          state_d   = PENABLE ? SETUP : IDLE;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          prdata_d  = '0;
        end else begin
          cnt_d = cnt_q - WC_W'(1);
          raise = (cnt_q == WC_W'(1));
        end
      end
      default: state_d = IDLE;
    endcase

    if (raise) begin
      pready_d  = 1'b1;
      pslverr_d = cur_err;
      prdata_d  = (!cur_write && !cur_err) ? mem_rdata : '0;
    end

    if (viol) begin
      state_d   = IDLE;
      cnt_d     = '0;
      pready_d  = 1'b0;
      pslverr_d = 1'b0;
      prdata_d  = '0;
    end

    err_d = viol | (err_q & ~err_clr);
  end

  // FSM state, wait counter and latched request.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
    end
  end

  // Registered bus responses and the sticky violation flag.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      err_q     <= err_d;
    end
  end

  assign PREADY     = pready_q;
  assign PSLVERR    = pslverr_q;
  assign PRDATA     = prdata_q;
  assign err_sticky = err_q;

endmodule

// File: tb/tb_apb4_mem_slave.sv
// Self-checking bench for apb4_mem_slave against a word-array reference model.
`timescale 1ns/1ps
module tb_apb4_mem_slave;
  localparam int AW = 32, DW = 32, DEPTH = 256, MAXW = 5;
  localparam int WCW = $clog2(MAXW + 1);

  logic PCLK = 1'b0, PRESETn = 1'b0;
  logic PSELx = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0, err_clr = 1'b0;
  logic [AW-1:0]  PADDR = '0;
  logic [DW-1:0]  PWDATA = '0;
  logic [3:0]     PSTRB = '0;
  logic [WCW-1:0] wait_cycles = '0;
  logic           PREADY, PSLVERR, err_sticky;
  logic [DW-1:0]  PRDATA;

  int checks = 0, failures = 0;
  logic [31:0] mem_m [DEPTH];

  apb4_mem_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .MAX_WAIT(MAXW)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .wait_cycles(wait_cycles),
    .err_clr(err_clr), .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA),
    .err_sticky(err_sticky)
  );

  always #5 PCLK = ~PCLK;

  // ---------------- reference model ----------------
  function automatic bit m_err(input logic [31:0] a);
    return (a % 4 != 0) || ((a / 4) >= DEPTH);
  endfunction

  function automatic int m_cycles(input int wc);
    return ((wc > MAXW) ? MAXW : wc) + 2;
  endfunction

  task automatic m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx;
    if (m_err(a)) return;
    idx = int'(a / 4);
    for (int b = 0; b < 4; b++) begin
`ifdef APB_SLV_STRB_EN
      if (s[b]) mem_m[idx][b*8 +: 8] = d[b*8 +: 8];
`else
      mem_m[idx][b*8 +: 8] = d[b*8 +: 8];
`endif
    end
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    return m_err(a) ? 32'h0 : mem_m[int'(a / 4)];
  endfunction

  task automatic m_clear();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
  endtask

  // ---------------- bus driver ----------------
  // Starts at a negedge, drives one transfer, returns at the negedge after completion.
  // tail_ok reports that PSLVERR/PRDATA were 0 while PREADY was low, and that PREADY dropped.
  task automatic xfer(input bit wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int wc,
                      output logic [31:0] rd, output logic er, output int cyc, output bit tail_ok);
    int n;
    PSELx = 1; PENABLE = 0; PWRITE = wr; PADDR = a; PWDATA = d; PSTRB = s;
    wait_cycles = WCW'(wc);
    @(negedge PCLK);
    PENABLE = 1;
    wait_cycles = WCW'($urandom_range(0, 7));
    cyc = 2; tail_ok = 1; rd = '0; er = 0; n = 0;
    while (PREADY !== 1'b1 && n < 20) begin
      if (PSLVERR !== 1'b0 || PRDATA !== '0) tail_ok = 0;
      @(negedge PCLK); cyc++; n++;
    end
    if (n >= 20) cyc = -1;
    else begin rd = PRDATA; er = PSLVERR; end
    @(negedge PCLK);
    if (PREADY !== 1'b0 || PSLVERR !== 1'b0 || PRDATA !== '0) tail_ok = 0;
  endtask

  task automatic idle(input int n);
    PSELx = 0; PENABLE = 0;
    repeat (n) @(negedge PCLK);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    PRESETn = 0;
    repeat (2) @(negedge PCLK);
    checks++;
    if (PREADY !== 0 || PSLVERR !== 0 || PRDATA !== '0 || err_sticky !== 0) begin
      failures++;
      $display("FAIL reset: PREADY=%b PSLVERR=%b PRDATA=%h err_sticky=%b, expected all 0",
               PREADY, PSLVERR, PRDATA, err_sticky);
    end
    m_clear();
    PRESETn = 1;
    @(negedge PCLK);
  endtask

  task automatic test_zero_wait();
    logic [31:0] rd; logic er; int cy; bit tl;
    xfer(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, cy, tl);
    m_write(32'h10, 32'hDEADBEEF, 4'hF);
    checks++;
    if (cy !== 2 || er !== 0 || !tl) begin
      failures++;
      $display("FAIL zw_write: cycles=%0d err=%b tail=%0d, expected 2/0/1", cy, er, tl);
    end
    xfer(0, 32'h10, 32'h0, 4'h0, 0, rd, er, cy, tl);
    checks++;
    if (rd !== 32'hDEADBEEF || cy !== 2 || er !== 0 || !tl) begin
      failures++;
      $display("FAIL zw_read: data=%h cycles=%0d err=%b tail=%0d, expected deadbeef/2/0/1",
               rd, cy, er, tl);
    end
    idle(1);
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; logic er; int cy; bit tl;
    int wcs [4] = '{3, 7, 1, 6};
    foreach (wcs[i]) begin
      xfer(0, 32'h10, 32'h0, 4'h0, wcs[i], rd, er, cy, tl);
      checks++;
      if (cy !== m_cycles(wcs[i]) || rd !== m_read(32'h10) || er !== 0 || !tl) begin
        failures++;
        $display("FAIL wait_%0d: cycles=%0d data=%h err=%b tail=%0d, expected %0d/%h/0/1",
                 wcs[i], cy, rd, er, tl, m_cycles(wcs[i]), m_read(32'h10));
      end
      idle(1);
    end
  endtask

  task automatic test_strobe();
    logic [31:0] rd; logic er; int cy; bit tl;
    xfer(1, 32'h20, 32'h0, 4'hF, 0, rd, er, cy, tl);
    m_write(32'h20, 32'h0, 4'hF);
    xfer(1, 32'h20, 32'h11223344, 4'b0101, 1, rd, er, cy, tl);
    m_write(32'h20, 32'h11223344, 4'b0101);
    xfer(0, 32'h20, 32'h0, 4'h0, 0, rd, er, cy, tl);
    checks++;
    if (rd !== m_read(32'h20) || er !== 0) begin
      failures++;
      $display("FAIL strobe_0101: data=%h err=%b, expected %h/0", rd, er, m_read(32'h20));
    end
    xfer(1, 32'h20, 32'hFFFFFFFF, 4'b0000, 0, rd, er, cy, tl);
    m_write(32'h20, 32'hFFFFFFFF, 4'b0000);
    checks++;
    if (er !== 0 || cy !== 2) begin
      failures++;
      $display("FAIL strobe_zero_err: err=%b cycles=%0d, expected 0/2", er, cy);
    end
    xfer(0, 32'h20, 32'h0, 4'h0, 2, rd, er, cy, tl);
    checks++;
    if (rd !== m_read(32'h20)) begin
      failures++;
      $display("FAIL strobe_zero_data: data=%h, expected %h", rd, m_read(32'h20));
    end
    idle(1);
  endtask

  task automatic test_addr_err();
    logic [31:0] rd; logic er; int cy; bit tl;
    xfer(0, 32'h400, 32'h0, 4'h0, 0, rd, er, cy, tl);
    checks++;
    if (er !== 1 || rd !== 32'h0 || cy !== 2) begin
      failures++;
      $display("FAIL err_range: err=%b data=%h cycles=%0d, expected 1/0/2", er, rd, cy);
    end
    xfer(1, 32'h22, 32'hA5A5A5A5, 4'hF, 2, rd, er, cy, tl);
    checks++;
    if (er !== 1 || cy !== 4) begin
      failures++;
      $display("FAIL err_misalign: err=%b cycles=%0d, expected 1/4", er, cy);
    end
    xfer(0, 32'h20, 32'h0, 4'h0, 0, rd, er, cy, tl);
    checks++;
    if (rd !== m_read(32'h20) || er !== 0) begin
      failures++;
      $display("FAIL err_unchanged: data=%h err=%b, expected %h/0", rd, er, m_read(32'h20));
    end
    xfer(0, 32'h3FC, 32'h0, 4'h0, 0, rd, er, cy, tl);
    checks++;
    if (er !== 0 || rd !== m_read(32'h3FC)) begin
      failures++;
      $display("FAIL err_last_word: err=%b data=%h, expected 0/%h", er, rd, m_read(32'h3FC));
    end
    idle(1);
  endtask

  task automatic test_violation();
    logic [31:0] rd; logic er; int cy; bit tl;
    // Drop PSELx in the middle of a waited write.
    PSELx = 1; PENABLE = 0; PWRITE = 1; PADDR = 32'h30; PWDATA = 32'hCAFEF00D;
    PSTRB = 4'hF; wait_cycles = WCW'(4);
    @(negedge PCLK); PENABLE = 1;
    @(negedge PCLK); PSELx = 0; PENABLE = 0;
    @(negedge PCLK);
    checks++;
    if (err_sticky !== 1 || PREADY !== 0 || PSLVERR !== 0) begin
      failures++;
      $display("FAIL viol_drop: err_sticky=%b PREADY=%b PSLVERR=%b, expected 1/0/0",
               err_sticky, PREADY, PSLVERR);
    end
    idle(3);
    xfer(0, 32'h30, 32'h0, 4'h0, 0, rd, er, cy, tl);
    checks++;
    if (rd !== m_read(32'h30) || err_sticky !== 1) begin
      failures++;
      $display("FAIL viol_nocommit: data=%h sticky=%b, expected %h/1", rd, err_sticky, m_read(32'h30));
    end
    idle(1);
    err_clr = 1; @(negedge PCLK); err_clr = 0;
    checks++;
    if (err_sticky !== 0) begin
      failures++;
      $display("FAIL viol_clear: err_sticky=%b, expected 0", err_sticky);
    end
    // PENABLE without PSELx, together with err_clr: the set must win.
    PENABLE = 1; err_clr = 1; @(negedge PCLK); PENABLE = 0; err_clr = 0;
    checks++;
    if (err_sticky !== 1) begin
      failures++;
      $display("FAIL viol_set_wins: err_sticky=%b, expected 1", err_sticky);
    end
    err_clr = 1; @(negedge PCLK); err_clr = 0;
    // PSELx and PENABLE together straight from idle.
    PSELx = 1; PENABLE = 1; @(negedge PCLK);
    checks++;
    if (err_sticky !== 1 || PREADY !== 0) begin
      failures++;
      $display("FAIL viol_enable_idle: err_sticky=%b PREADY=%b, expected 1/0", err_sticky, PREADY);
    end
    idle(1);
    err_clr = 1; @(negedge PCLK); err_clr = 0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int cy; bit tl;
    PENABLE = 1; @(negedge PCLK); PENABLE = 0;      // set err_sticky
    PSELx = 1; PENABLE = 0; PWRITE = 1; PADDR = 32'h40; PWDATA = 32'h12345678;
    PSTRB = 4'hF; wait_cycles = WCW'(5);
    @(negedge PCLK); PENABLE = 1;
    repeat (2) @(negedge PCLK);
    #2 PRESETn = 0;
    #1;
    checks++;
    if (PREADY !== 0 || PSLVERR !== 0 || PRDATA !== '0 || err_sticky !== 0) begin
      failures++;
      $display("FAIL reset_mid: PREADY=%b PSLVERR=%b PRDATA=%h sticky=%b, expected all 0",
               PREADY, PSLVERR, PRDATA, err_sticky);
    end
    @(negedge PCLK);
    PSELx = 0; PENABLE = 0; PRESETn = 1;
    m_clear();
    @(negedge PCLK);
    xfer(0, 32'h10, 32'h0, 4'h0, 0, rd, er, cy, tl);
    checks++;
    if (rd !== m_read(32'h10) || er !== 0) begin
      failures++;
      $display("FAIL reset_mem_clear: data=%h err=%b, expected %h/0", rd, er, m_read(32'h10));
    end
    xfer(0, 32'h40, 32'h0, 4'h0, 0, rd, er, cy, tl);
    checks++;
    if (rd !== m_read(32'h40)) begin
      failures++;
      $display("FAIL reset_no_commit: data=%h, expected %h", rd, m_read(32'h40));
    end
    idle(1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int cy, cy2; bit tl;
    xfer(1, 32'h0, 32'h0BADF00D, 4'hF, 0, rd, er, cy, tl);
    m_write(32'h0, 32'h0BADF00D, 4'hF);
    xfer(1, 32'h4, 32'h76543210, 4'hF, 0, rd, er, cy2, tl);
    m_write(32'h4, 32'h76543210, 4'hF);
    checks++;
    if (cy !== 2 || cy2 !== 2 || err_sticky !== 0) begin
      failures++;
      $display("FAIL b2b_timing: cycles=%0d,%0d sticky=%b, expected 2,2/0", cy, cy2, err_sticky);
    end
    xfer(0, 32'h0, 32'h0, 4'h0, 0, rd, er, cy, tl);
    checks++;
    if (rd !== m_read(32'h0)) begin
      failures++;
      $display("FAIL b2b_word0: data=%h, expected %h", rd, m_read(32'h0));
    end
    xfer(0, 32'h4, 32'h0, 4'h0, 1, rd, er, cy, tl);
    checks++;
    if (rd !== m_read(32'h4)) begin
      failures++;
      $display("FAIL b2b_word1: data=%h, expected %h", rd, m_read(32'h4));
    end
    idle(1);
  endtask

  task automatic test_random();
    logic [31:0] rd, a, d; logic er; int cy, wc; bit tl, wr; logic [3:0] s;
    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 9))
        7:       a = (32'd256 + $urandom_range(0, 1000)) * 4;
        8:       a = $urandom_range(0, 15) * 4 + $urandom_range(1, 3);
        9:       a = 32'hFFFF_FF00 | ($urandom_range(0, 63) * 4);
        default: a = $urandom_range(0, 15) * 4;
      endcase
      wr = 1'($urandom_range(0, 1));
      d  = $urandom;
      s  = 4'($urandom_range(0, 15));
      wc = $urandom_range(0, 7);
      xfer(wr, a, d, s, wc, rd, er, cy, tl);
      checks++;
      if (er !== m_err(a) || cy !== m_cycles(wc) || !tl ||
          (!wr && rd !== m_read(a)) || (wr && rd !== '0)) begin
        failures++;
        $display("FAIL rand_%0d: wr=%0d addr=%h data=%h err=%b cycles=%0d tail=%0d, expected data=%h err=%b cycles=%0d",
                 it, wr, a, rd, er, cy, tl, wr ? 32'h0 : m_read(a), m_err(a), m_cycles(wc));
      end
      if (wr) m_write(a, d, s);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
    idle(1);
    checks++;
    if (err_sticky !== 0) begin
      failures++;
      $display("FAIL rand_sticky: err_sticky=%b, expected 0", err_sticky);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_strobe();
    test_addr_err();
    test_violation();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

endmodule
